// File: rtl/endstop_pkg.sv
// Shared constants and types for the endstop filter bank.
// Optional feature macro: ENDSTOP_LATCH_EN (sticky hit latch per channel).
package endstop_pkg;

  // Widest bank the filter supports.
  localparam int ENDSTOP_MAX_CH = 32;

  // Default number of consecutive mismatching samples needed to change state.
  localparam int ENDSTOP_DEBOUNCE_DEFAULT = 10000;

  // Full-width channel vector, used wherever a bank-independent width is handy.
  typedef logic [ENDSTOP_MAX_CH-1:0] endstop_vec_t;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int endstop_cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/endstop_channel.sv
// One endstop channel: two-flop synchroniser, polarity correction,
// consecutive-sample debounce counter, edge pulses and optional sticky hit flag.
// Optional feature macro: ENDSTOP_LATCH_EN (when undefined hit_latched is 0
// and clr is ignored).
module endstop_channel
  import endstop_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = ENDSTOP_DEBOUNCE_DEFAULT,
  parameter logic INV             = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic clr,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hit_latched
);

  localparam int            CW       = endstop_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          sample;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          out_reg;
  logic          out_next;
  logic          rise_reg;
  logic          rise_next;
  logic          fall_reg;
  logic          fall_next;

  // Synchroniser; resets to the inactive pin level so the first sample is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= INV;
      sync2_reg <= INV;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
    end
  end

  // Active-low pins are flipped here so 1 always means "triggered".
  assign sample = sync2_reg ^ INV;

  // Debounce decision: any agreeing sample restarts the count; the
  // DEBOUNCE_CYCLES-th consecutive disagreeing sample flips the output.
  always_comb begin
    cnt_next  = '0;
    out_next  = out_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (sample == out_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next  = '0;
      out_next  = sample;
      rise_next = sample;
      fall_next = ~sample;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Debounce state and edge pulses; pulses share the cycle of the out change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      out_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      out_reg  <= out_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign out  = out_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

`ifdef ENDSTOP_LATCH_EN
  logic hit_reg;
  logic hit_next;

  // Sticky flag: set by a rise pulse, cleared by clr; set beats clear.
  always_comb begin
    hit_next = rise_reg | (hit_reg & ~clr);
  end

  // Hit flag register; it trails the rise pulse by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_reg <= 1'b0;
    end else begin
      hit_reg <= hit_next;
    end
  end

  assign hit_latched = hit_reg;
`else
  // Latch removed: clr is deliberately left without a load.
  logic clr_unused;
  assign clr_unused  = clr;
  assign hit_latched = 1'b0;
`endif

endmodule

// File: rtl/endstop_filter_bank.sv
// Multi-channel endstop debouncer: N_CH independent endstop_channel instances
// plus a registered OR of all debounced levels.
// Optional feature macro: ENDSTOP_LATCH_EN (sticky hit latch and clr input).
module endstop_filter_bank
  import endstop_pkg::*;
#(
  parameter int              N_CH            = 3,
  parameter int              DEBOUNCE_CYCLES = ENDSTOP_DEBOUNCE_DEFAULT,
  parameter logic [N_CH-1:0] INV_MASK        = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hit_latched,
  input  logic [N_CH-1:0] clr,
  output logic            any_out
);

  endstop_vec_t out_wide;
  logic         any_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      endstop_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INV            (INV_MASK[gi])
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (in[gi]),
        .clr        (clr[gi]),
        .out        (out[gi]),
        .rise       (rise[gi]),
        .fall       (fall[gi]),
        .hit_latched(hit_latched[gi])
      );
    end
  endgenerate

  // Zero-extend the bank to full width so the OR is independent of N_CH.
  always_comb begin
    out_wide           = '0;
    out_wide[N_CH-1:0] = out;
  end

  // Registered "any endstop triggered"; one cycle behind out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_reg <= 1'b0;
    end else begin
      any_reg <= |out_wide;
    end
  end

  assign any_out = any_reg;

endmodule

// File: tb/tb_endstop_filter_bank.sv
// Self-checking bench for endstop_filter_bank (N_CH=3, DEBOUNCE_CYCLES=8,
// INV_MASK=3'b010). A sliding-window reference model is checked every cycle;
// directed steps pin literal latencies and pulse shapes.
module tb_endstop_filter_bank;

  localparam int         N   = 3;
  localparam int         D   = 8;
  localparam logic [2:0] INV = 3'b010;

`ifdef ENDSTOP_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] in    = INV;
  logic [2:0] clr   = 3'b000;
  logic [2:0] out, rise, fall, hit_latched;
  logic       any_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  endstop_filter_bank #(
    .N_CH           (N),
    .DEBOUNCE_CYCLES(D),
    .INV_MASK       (INV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .hit_latched(hit_latched),
    .clr        (clr),
    .any_out    (any_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins reach the decision point two edges late; out flips once the last D
  // samples all disagree with it.
  logic [2:0]   m_out = '0, m_rise = '0, m_fall = '0, m_hit = '0;
  logic         m_any = 1'b0;
  logic [2:0]   d0 = '0, d1 = '0, s_now;
  logic [D-1:0] win  [N];
  int           nval [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_rise = '0; m_fall = '0; m_hit = '0; m_any = 1'b0;
      d0 = '0; d1 = '0;
      for (int c = 0; c < N; c++) begin
        win[c]  = '0;
        nval[c] = 0;
      end
    end else begin
      m_any = |m_out;
      m_hit = LATCH ? (m_rise | (m_hit & ~clr)) : 3'b000;
      s_now = d1;
      d1    = d0;
      d0    = in ^ INV;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) begin
        win[c] = {win[c][D-2:0], s_now[c]};
        if (nval[c] < D) nval[c]++;
        if (nval[c] == D && win[c] == {D{~m_out[c]}}) begin
          m_out[c] = ~m_out[c];
          if (m_out[c]) m_rise[c] = 1'b1;
          else          m_fall[c] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", {29'd0, out}, {29'd0, m_out});
      chk("rise", {29'd0, rise}, {29'd0, m_rise});
      chk("fall", {29'd0, fall}, {29'd0, m_fall});
      chk("hit_latched", {29'd0, hit_latched}, {29'd0, m_hit});
      chk("any_out", {31'd0, any_out}, {31'd0, m_any});
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic pick(input int sel, input int c);
    case (sel)
      0:       return out[c];
      1:       return rise[c];
      2:       return fall[c];
      default: return hit_latched[c];
    endcase
  endfunction

  task automatic wait_bit(input string name, input int sel, input int c,
                          input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pick(sel, c) && n < limit);
    if (!pick(sel, c)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: actual=no event required=event within %0d cycles", name, limit);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int prob;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state with pins idle at their inactive levels.
    chk("reset_out", {29'd0, out}, 32'd0);
    chk("reset_rise", {29'd0, rise}, 32'd0);
    chk("reset_fall", {29'd0, fall}, 32'd0);
    chk("reset_hit", {29'd0, hit_latched}, 32'd0);
    chk("reset_any", {31'd0, any_out}, 32'd0);
    cycles(12);
    chk("idle_out", {29'd0, out}, 32'd0);

    // Stable press on channel 0: out rises 10 cycles later, single pulse.
    in[0] = 1'b1;
    wait_bit("t2_rise", 0, 0, 40, n);
    chk("t2_rise_latency", n, 10);
    chk("t2_rise_pulse", {29'd0, rise}, 32'd1);
    @(negedge clk);
    chk("t2_rise_once", {29'd0, rise}, 32'd0);
    chk("t2_out_hold", {31'd0, out[0]}, 32'd1);
    in[0] = 1'b0;
    wait_bit("t2_fall", 2, 0, 40, n);
    chk("t2_fall_latency", n, 10);
    cycles(3);

    // 7-cycle glitch is rejected, 8-cycle pulse is accepted.
    in[0] = 1'b1;
    cycles(7);
    in[0] = 1'b0;
    cycles(12);
    chk("t3_glitch7_out", {31'd0, out[0]}, 32'd0);
    in[0] = 1'b1;
    cycles(8);
    in[0] = 1'b0;
    cycles(2);
    chk("t3_glitch8_out", {31'd0, out[0]}, 32'd1);
    chk("t3_glitch8_rise", {31'd0, rise[0]}, 32'd1);
    wait_bit("t3_fall", 2, 0, 30, n);
    cycles(3);

    // Active-low channel 1.
    in[1] = 1'b0;
    cycles(10);
    chk("t4_out1", {31'd0, out[1]}, 32'd1);
    in[1] = 1'b1;
    wait_bit("t4_fall", 2, 1, 30, n);
    chk("t4_fall_latency", n, 10);
    cycles(3);

    // Sticky hit on channel 2, then clear, then set-beats-clear.
    in[2] = 1'b1;
    cycles(9);
    in[2] = 1'b0;
    cycles(25);
    chk("t5_out2", {31'd0, out[2]}, 32'd0);
    chk("t5_hit_sticky", {31'd0, hit_latched[2]}, {31'd0, LATCH});
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    chk("t5_hit_cleared", {31'd0, hit_latched[2]}, 32'd0);
    in[2] = 1'b1;
    wait_bit("t5_rise2", 1, 2, 30, n);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    chk("t5_set_wins", {31'd0, hit_latched[2]}, {31'd0, LATCH});
    in[2] = 1'b0;
    cycles(20);

    // All channels at once; any_out follows a cycle later.
    in = ~INV;
    wait_bit("t6_rise", 1, 0, 30, n);
    chk("t6_rise_all", {29'd0, rise}, 32'd7);
    chk("t6_any_lag", {31'd0, any_out}, 32'd0);
    @(negedge clk);
    chk("t6_any", {31'd0, any_out}, 32'd1);
    chk("t6_rise_off", {29'd0, rise}, 32'd0);

    // Reset while triggered: out drops with no fall pulse.
    cycles(3);
    do_reset();
    chk("t7_out", {29'd0, out}, 32'd0);
    chk("t7_fall", {29'd0, fall}, 32'd0);
    @(negedge clk);
    chk("t7_fall_next", {29'd0, fall}, 32'd0);
    in = INV;
    cycles(15);

    // Randomised phase with varying toggle rates, random clr and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      case ((i / 500) % 3)
        0:       prob = 3;
        1:       prob = 8;
        default: prob = 20;
      endcase
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 99) < prob) in[c] = ~in[c];
        clr[c] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
